// File: rtl/led_pattern_sequencer_if.sv
// ROM read-port bundle between the LED pattern sequencer (master) and the pattern ROM (slave).
interface led_pattern_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_en, output rom_addr, input rom_data);
    modport slave  (input rom_en, input rom_addr, output rom_data);
endinterface

// File: rtl/led_pattern_sequencer.sv
// Steps through the LED pattern ROM at a prescaled rate, one registered read per step.
// Optional macro LED_SEQ_BLANK_EN: blank the LEDs while the sequencer is stopped.
module led_pattern_sequencer #(
    parameter int STEP_DIV  = 50_000_000,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 4,
    parameter int LAST_ADDR = 4095
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_run,
    input  logic                    i_dir,
    led_pattern_sequencer_if.master rom,
    output logic [DATA_W-1:0]       o_led,
    output logic                    o_step
);

    localparam int                CNT_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEP_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_rom_en;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [DATA_W-1:0]  r_led;
    logic               r_step;
    logic               w_tick;
    logic [ADDR_W-1:0]  w_addr_next;

    assign rom.rom_en   = r_rom_en;
    assign rom.rom_addr = r_rom_addr;
    assign o_led        = r_led;
    assign o_step       = r_step;

    // Stopping parks the prescaler at zero so a restart waits a full step period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_run || r_count == CNT_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign w_tick = i_run && (r_count == CNT_LAST);

    always_comb begin
        w_addr_next = r_rom_addr;
        if (i_dir) begin
            w_addr_next = (r_rom_addr == '0) ? ADDR_LAST : r_rom_addr - ADDR_W'(1);
        end else begin
            w_addr_next = (r_rom_addr == ADDR_LAST) ? '0 : r_rom_addr + ADDR_W'(1);
        end
    end

    // The address only moves after the ROM has sampled it, so it is stable across the read edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_led      <= '0;
            r_step     <= 1'b0;
        end else begin
            r_rom_en <= 1'b0;
            r_step   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state  <= S_ISSUE;
                        r_rom_en <= 1'b1;
                    end
`ifdef LED_SEQ_BLANK_EN
                    else if (!i_run) begin
                        r_led <= '0;
                    end
`endif
                end
                S_ISSUE: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_led      <= rom.rom_data;
                    r_step     <= 1'b1;
                    r_rom_addr <= w_addr_next;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed testbench for led_pattern_sequencer with STEP_DIV=4 and a ROM returning addr[3:0].
module tb_led_pattern_sequencer;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 4;
    localparam int STEP_DIV  = 4;
    localparam int LAST_ADDR = 4095;
`ifdef LED_SEQ_BLANK_EN
    localparam logic [DATA_W-1:0] STOP_LED = 4'h0;
`else
    localparam logic [DATA_W-1:0] STOP_LED = 4'hD;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              run;
    logic              dir;
    logic [DATA_W-1:0] led;
    logic              stepPulse;
    int                testsRun = 0;
    int                testsFailed = 0;

    led_pattern_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) romIf ();

    led_pattern_sequencer #(
        .STEP_DIV (STEP_DIV),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LAST_ADDR(LAST_ADDR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_run (run),
        .i_dir (dir),
        .rom   (romIf),
        .o_led (led),
        .o_step(stepPulse)
    );

    always #5 clk = ~clk;

    // One-cycle registered ROM whose content at each address is the address low nibble.
    always @(posedge clk) begin
        if (romIf.rom_en) romIf.rom_data <= romIf.rom_addr[DATA_W-1:0];
    end

    task automatic waitRead(input int budget, output int gap, output logic [ADDR_W-1:0] addr);
        gap = 0;
        while (romIf.rom_en !== 1'b1 && gap < budget) begin
            @(negedge clk);
            gap++;
        end
        if (romIf.rom_en !== 1'b1) gap = -1;
        addr = romIf.rom_addr;
    endtask

    task automatic captureRead(output logic enAfter, output logic [DATA_W-1:0] ledV, output logic stepV);
        @(negedge clk);
        enAfter = romIf.rom_en;
        @(negedge clk);
        ledV  = led;
        stepV = stepPulse;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; dir = 1'b0;
        repeat (3) @(negedge clk);
        testsRun++; if (romIf.rom_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rom_en: got %b expected 0", romIf.rom_en); end
        testsRun++; if (romIf.rom_addr !== 12'd0) begin testsFailed++; $display("[TB] FAIL reset_rom_addr: got %0d expected 0", romIf.rom_addr); end
        testsRun++; if (led !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_led: got %0h expected 0", led); end
        testsRun++; if (stepPulse !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_step: got %b expected 0", stepPulse); end
    endtask

    task automatic test_sequence();
        int gap; logic [ADDR_W-1:0] a; logic e; logic [DATA_W-1:0] lv; logic sv;
        rst_n = 1'b1; run = 1'b1; dir = 1'b0;
        for (int k = 0; k < 4; k++) begin
            waitRead(8, gap, a);
            captureRead(e, lv, sv);
            testsRun++; if (gap != ((k == 0) ? 4 : 2)) begin testsFailed++; $display("[TB] FAIL seq_gap k=%0d: got %0d expected %0d", k, gap, (k == 0) ? 4 : 2); end
            testsRun++; if (a !== 12'(k)) begin testsFailed++; $display("[TB] FAIL seq_addr k=%0d: got %0d expected %0d", k, a, k); end
            testsRun++; if (e !== 1'b0) begin testsFailed++; $display("[TB] FAIL seq_en_single k=%0d: got %b expected 0", k, e); end
            testsRun++; if (lv !== 4'(k)) begin testsFailed++; $display("[TB] FAIL seq_led k=%0d: got %0h expected %0h", k, lv, k); end
            testsRun++; if (sv !== 1'b1) begin testsFailed++; $display("[TB] FAIL seq_step k=%0d: got %b expected 1", k, sv); end
        end
    endtask

    task automatic test_wrap();
        int gap; int bad = 0; logic [ADDR_W-1:0] a = '0; logic e; logic [DATA_W-1:0] lv = '0; logic sv;
        for (int i = 4; i <= LAST_ADDR; i++) begin
            waitRead(8, gap, a);
            captureRead(e, lv, sv);
            if (gap != 2 || a !== 12'(i) || e !== 1'b0 || lv !== 4'(i) || sv !== 1'b1) bad++;
            if (gap < 0) break;
        end
        testsRun++; if (bad != 0) begin testsFailed++; $display("[TB] FAIL wrap_walk: got %0d bad steps expected 0", bad); end
        testsRun++; if (a !== 12'd4095) begin testsFailed++; $display("[TB] FAIL wrap_last_addr: got %0d expected 4095", a); end
        testsRun++; if (lv !== 4'hF) begin testsFailed++; $display("[TB] FAIL wrap_last_led: got %0h expected f", lv); end
        dir = 1'b1;
    endtask

    task automatic test_reverse();
        int gap; logic [ADDR_W-1:0] a; logic e; logic [DATA_W-1:0] lv; logic sv;
        logic [ADDR_W-1:0] expA [3] = '{12'd0, 12'd4095, 12'd4094};
        logic [DATA_W-1:0] expL [3] = '{4'h0, 4'hF, 4'hE};
        for (int k = 0; k < 3; k++) begin
            waitRead(8, gap, a);
            captureRead(e, lv, sv);
            testsRun++; if (gap != 2) begin testsFailed++; $display("[TB] FAIL rev_gap k=%0d: got %0d expected 2", k, gap); end
            testsRun++; if (a !== expA[k]) begin testsFailed++; $display("[TB] FAIL rev_addr k=%0d: got %0d expected %0d", k, a, expA[k]); end
            testsRun++; if (lv !== expL[k]) begin testsFailed++; $display("[TB] FAIL rev_led k=%0d: got %0h expected %0h", k, lv, expL[k]); end
        end
    endtask

    task automatic test_stop();
        int gap; int enCount = 0; logic [ADDR_W-1:0] a; logic e; logic [DATA_W-1:0] lv; logic sv;
        waitRead(8, gap, a);
        run = 1'b0;
        captureRead(e, lv, sv);
        testsRun++; if (a !== 12'd4093) begin testsFailed++; $display("[TB] FAIL stop_addr: got %0d expected 4093", a); end
        testsRun++; if (e !== 1'b0) begin testsFailed++; $display("[TB] FAIL stop_en_single: got %b expected 0", e); end
        testsRun++; if (lv !== 4'hD || sv !== 1'b1) begin testsFailed++; $display("[TB] FAIL stop_drain_led: got led %0h step %b expected d 1", lv, sv); end
        repeat (12) begin
            @(negedge clk);
            if (romIf.rom_en === 1'b1) enCount++;
        end
        testsRun++; if (enCount != 0) begin testsFailed++; $display("[TB] FAIL stop_no_reads: got %0d reads expected 0", enCount); end
        testsRun++; if (led !== STOP_LED) begin testsFailed++; $display("[TB] FAIL stop_led_hold: got %0h expected %0h", led, STOP_LED); end
        testsRun++; if (romIf.rom_addr !== 12'd4092) begin testsFailed++; $display("[TB] FAIL stop_addr_adv: got %0d expected 4092", romIf.rom_addr); end
    endtask

    task automatic test_restart();
        int gap; logic [ADDR_W-1:0] a; logic e; logic [DATA_W-1:0] lv; logic sv;
        run = 1'b1;
        waitRead(8, gap, a);
        captureRead(e, lv, sv);
        testsRun++; if (gap != 4) begin testsFailed++; $display("[TB] FAIL restart_gap: got %0d expected 4", gap); end
        testsRun++; if (a !== 12'd4092) begin testsFailed++; $display("[TB] FAIL restart_addr: got %0d expected 4092", a); end
        testsRun++; if (lv !== 4'hC) begin testsFailed++; $display("[TB] FAIL restart_led: got %0h expected c", lv); end
    endtask

    task automatic test_dir_toggle();
        int gap; logic [ADDR_W-1:0] a; logic e; logic [DATA_W-1:0] lv; logic sv;
        waitRead(8, gap, a);
        dir = 1'b0;
        captureRead(e, lv, sv);
        testsRun++; if (a !== 12'd4091 || lv !== 4'hB) begin testsFailed++; $display("[TB] FAIL toggle_first: got addr %0d led %0h expected 4091 b", a, lv); end
        waitRead(8, gap, a);
        captureRead(e, lv, sv);
        testsRun++; if (a !== 12'd4092) begin testsFailed++; $display("[TB] FAIL toggle_new_dir: got %0d expected 4092", a); end
        testsRun++; if (lv !== 4'hC) begin testsFailed++; $display("[TB] FAIL toggle_led: got %0h expected c", lv); end
    endtask

    task automatic test_reset_mid();
        int gap; logic [ADDR_W-1:0] a; logic e; logic [DATA_W-1:0] lv; logic sv;
        waitRead(8, gap, a);
        testsRun++; if (a !== 12'd4093) begin testsFailed++; $display("[TB] FAIL rstmid_pre_addr: got %0d expected 4093", a); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        testsRun++; if (led !== 4'h0) begin testsFailed++; $display("[TB] FAIL rstmid_led: got %0h expected 0", led); end
        testsRun++; if (romIf.rom_addr !== 12'd0) begin testsFailed++; $display("[TB] FAIL rstmid_addr: got %0d expected 0", romIf.rom_addr); end
        testsRun++; if (romIf.rom_en !== 1'b0 || stepPulse !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_en_step: got %b %b expected 0 0", romIf.rom_en, stepPulse); end
        @(negedge clk);
        testsRun++; if (led !== 4'h0) begin testsFailed++; $display("[TB] FAIL rstmid_discard: got %0h expected 0", led); end
        rst_n = 1'b1;
        waitRead(8, gap, a);
        captureRead(e, lv, sv);
        testsRun++; if (gap != 4 || a !== 12'd0) begin testsFailed++; $display("[TB] FAIL rstmid_first_read: got gap %0d addr %0d expected 4 0", gap, a); end
        waitRead(8, gap, a);
        captureRead(e, lv, sv);
        testsRun++; if (a !== 12'd1 || lv !== 4'h1) begin testsFailed++; $display("[TB] FAIL rstmid_resume: got addr %0d led %0h expected 1 1", a, lv); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_wrap();
        test_reverse();
        test_stop();
        test_restart();
        test_dir_toggle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
